// File: rtl/imem_responder_pkg.sv
// Shared constants and state encoding for the instruction-memory responder.
package imem_pkg;

  localparam logic [31:0] RESET_PC = 32'h0001_0000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    READY = 2'd2
  } imem_state_e;

endpackage

// File: rtl/imem_responder_array.sv
// Word-wide program RAM: one synchronous write port, one registered read port.
// A read and write to the same index at the same edge returns the written data.
module imem_array #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [31:0]       i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [31:0]       o_rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [31:0] r_mem [0:DEPTH-1];
  logic [31:0] r_rdata;

  // Write port plus registered write-first read.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_we && (i_waddr == i_raddr)) begin
      r_rdata <= i_wdata;
    end else begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: captures fetch addresses, inserts configurable
// wait states, returns the program word (or a fault word) and counts stalls.
module imem_responder
  import imem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = RESET_PC,
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned LATENCY    = 1,
  parameter logic [31:0] FAULT_WORD = NOP_WORD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       iaddr,
  output logic [31:0]       idata,
  output logic              iready_n,
  output logic              ifault,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  output logic [31:0]       stall_count
);

  imem_state_e       r_state;
  imem_state_e       w_state_nxt;
  logic [31:0]       r_addr;
  logic [31:0]       w_addr_nxt;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_nxt;
  logic [31:0]       r_idata;
  logic              r_ifault;
  logic [31:0]       r_stall;
  logic              w_complete;
  logic              w_capture;
  logic              w_ld_hit;
  logic [29:0]       w_qword;
  logic              w_fault_q;
  logic [ADDR_W-1:0] w_idx_q;
  logic [ADDR_W-1:0] w_idx_in;
  logic [ADDR_W-1:0] w_raddr;
  logic [31:0]       w_rdata;
  logic              w_iready_n;

  // Word offset of the held address, used both for decode and RAM indexing.
  assign w_qword   = 30'((r_addr - BASE_ADDR) >> 2);
  assign w_idx_q   = w_qword[ADDR_W-1:0];
  assign w_fault_q = (r_addr[1:0] != 2'b00) || ((w_qword >> ADDR_W) != '0);
  assign w_idx_in  = ADDR_W'((iaddr - BASE_ADDR) >> 2);

  assign w_capture = (r_state == IDLE) || (iaddr != r_addr);
  assign w_ld_hit  = ld_we && (ld_addr == w_idx_q) && (r_state != IDLE);

  // The RAM read is issued one edge ahead at the index that will be held next,
  // so its registered output is current when the wait count expires.
  assign w_raddr = w_capture ? w_idx_in : w_idx_q;

  imem_array #(
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk    (clk),
    .i_we   (ld_we),
    .i_waddr(ld_addr),
    .i_wdata(ld_data),
    .i_raddr(w_raddr),
    .o_rdata(w_rdata)
  );

  // Next-state logic: address change or a write to the held word restarts the access.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_cnt_nxt   = r_cnt;
    w_complete  = 1'b0;
    if (w_capture) begin
      w_addr_nxt  = iaddr;
      w_cnt_nxt   = 4'(LATENCY);
      w_state_nxt = BUSY;
    end else if (w_ld_hit) begin
      w_cnt_nxt   = 4'(LATENCY);
      w_state_nxt = BUSY;
    end else begin
      unique case (r_state)
        BUSY: begin
          if (r_cnt != 4'd0) begin
            w_cnt_nxt = r_cnt - 4'd1;
          end else begin
            w_state_nxt = READY;
            w_complete  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // State register and returned-word capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_cnt    <= '0;
      r_idata  <= '0;
      r_ifault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_complete) begin
        r_idata  <= w_fault_q ? FAULT_WORD : w_rdata;
        r_ifault <= w_fault_q;
      end
    end
  end

  assign w_iready_n = !((r_state == READY) && (iaddr == r_addr));

  // Saturating count of cycles the fetch stage is held off.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall <= '0;
    end else if (w_iready_n && (r_state != IDLE) && (r_stall != '1)) begin
      r_stall <= r_stall + 32'd1;
    end
  end

  assign idata       = r_idata;
  assign ifault      = r_ifault;
  assign iready_n    = w_iready_n;
  assign stall_count = r_stall;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: one instance at LATENCY=1, one at LATENCY=3.
module tb_imem_responder;

  logic        clk;
  logic        rst;
  logic [31:0] iaddr;
  logic [31:0] iaddr3;
  logic        ld_we;
  logic [11:0] ld_addr;
  logic [31:0] ld_data;

  logic [31:0] idata, idata3;
  logic        iready_n, iready_n3;
  logic        ifault, ifault3;
  logic [31:0] stall_count, stall_count3;

  int unsigned n_vec;
  int unsigned n_bad;

  logic [31:0] prog [0:3];

  imem_responder #(
    .BASE_ADDR (32'h0001_0000),
    .ADDR_W    (12),
    .LATENCY   (1),
    .FAULT_WORD(32'h0000_0013)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .iaddr      (iaddr),
    .idata      (idata),
    .iready_n   (iready_n),
    .ifault     (ifault),
    .ld_we      (ld_we),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .stall_count(stall_count)
  );

  imem_responder #(
    .BASE_ADDR (32'h0001_0000),
    .ADDR_W    (12),
    .LATENCY   (3),
    .FAULT_WORD(32'h0000_0013)
  ) dut3 (
    .clk        (clk),
    .rst        (rst),
    .iaddr      (iaddr3),
    .idata      (idata3),
    .iready_n   (iready_n3),
    .ifault     (ifault3),
    .ld_we      (ld_we),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .stall_count(stall_count3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Program load during reset, then reset-state and first-access timing.
  task automatic test_reset;
    rst    = 1'b1;
    iaddr  = 32'h0001_0000;
    iaddr3 = 32'h0001_0000;
    for (int i = 0; i < 4; i++) begin
      ld_we   = 1'b1;
      ld_addr = 12'(i);
      ld_data = prog[i];
      tick();
    end
    ld_we = 1'b0;
    tick();
    n_vec++; if (iready_n !== 1'b1) begin n_bad++; $display("FAIL rst_iready_n: got %b want 1", iready_n); end
    n_vec++; if (idata !== 32'h0) begin n_bad++; $display("FAIL rst_idata: got %h want 00000000", idata); end
    n_vec++; if (ifault !== 1'b0) begin n_bad++; $display("FAIL rst_ifault: got %b want 0", ifault); end
    n_vec++; if (stall_count !== 32'h0) begin n_bad++; $display("FAIL rst_stall: got %0d want 0", stall_count); end
    rst = 1'b0;
    tick();
    n_vec++; if (iready_n !== 1'b1) begin n_bad++; $display("FAIL rel_e0_busy: got %b want 1", iready_n); end
    tick();
    n_vec++; if (iready_n !== 1'b1) begin n_bad++; $display("FAIL rel_e1_busy: got %b want 1", iready_n); end
    tick();
    n_vec++; if (iready_n !== 1'b0) begin n_bad++; $display("FAIL rel_e2_ready: got %b want 0", iready_n); end
    n_vec++; if (idata !== 32'h0000_0093) begin n_bad++; $display("FAIL rel_idata: got %h want 00000093", idata); end
    n_vec++; if (stall_count !== 32'd2) begin n_bad++; $display("FAIL rel_stall: got %0d want 2", stall_count); end
  endtask

  // Step through the program words; each access busy for capture + LATENCY+1 edges.
  task automatic test_sequential;
    for (int k = 1; k < 4; k++) begin
      iaddr = 32'h0001_0000 + 32'(4 * k);
      #1;
      n_vec++; if (iready_n !== 1'b1) begin n_bad++; $display("FAIL seq%0d_comb_drop: got %b want 1", k, iready_n); end
      tick();
      n_vec++; if (iready_n !== 1'b1) begin n_bad++; $display("FAIL seq%0d_busy0: got %b want 1", k, iready_n); end
      tick();
      n_vec++; if (iready_n !== 1'b1) begin n_bad++; $display("FAIL seq%0d_busy1: got %b want 1", k, iready_n); end
      tick();
      n_vec++; if (iready_n !== 1'b0) begin n_bad++; $display("FAIL seq%0d_ready: got %b want 0", k, iready_n); end
      n_vec++; if (idata !== prog[k]) begin n_bad++; $display("FAIL seq%0d_idata: got %h want %h", k, idata, prog[k]); end
      n_vec++; if (ifault !== 1'b0) begin n_bad++; $display("FAIL seq%0d_ifault: got %b want 0", k, ifault); end
    end
    n_vec++; if (stall_count !== 32'd11) begin n_bad++; $display("FAIL seq_stall: got %0d want 11", stall_count); end
  endtask

  // Same address held: stays ready, no re-access, no stall counted.
  task automatic test_keep;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++; if (iready_n !== 1'b0) begin n_bad++; $display("FAIL keep%0d_ready: got %b want 0", i, iready_n); end
      n_vec++; if (idata !== 32'h0030_0213) begin n_bad++; $display("FAIL keep%0d_idata: got %h want 00300213", i, idata); end
    end
    n_vec++; if (stall_count !== 32'd11) begin n_bad++; $display("FAIL keep_stall: got %0d want 11", stall_count); end
  endtask

  // LATENCY=3: abandon 0x10004 mid-access, expect only 0x10008 to complete.
  task automatic test_abort_lat3;
    n_vec++; if (iready_n3 !== 1'b0) begin n_bad++; $display("FAIL l3_init_ready: got %b want 0", iready_n3); end
    iaddr3 = 32'h0001_0004;
    tick();
    tick();
    iaddr3 = 32'h0001_0008;
    #1;
    n_vec++; if (iready_n3 !== 1'b1) begin n_bad++; $display("FAIL l3_switch_busy: got %b want 1", iready_n3); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++; if (iready_n3 !== 1'b1) begin n_bad++; $display("FAIL l3_busy%0d: got %b want 1", i, iready_n3); end
    end
    tick();
    n_vec++; if (iready_n3 !== 1'b0) begin n_bad++; $display("FAIL l3_ready: got %b want 0", iready_n3); end
    n_vec++; if (idata3 !== 32'h0020_0193) begin n_bad++; $display("FAIL l3_idata: got %h want 00200193", idata3); end
  endtask

  // Misaligned, past-end and below-base fetches all return the fault word.
  task automatic test_fault;
    logic [31:0] addrs [0:3];
    logic [31:0] want_d [0:3];
    logic        want_f [0:3];
    addrs[0] = 32'h0001_0002; want_d[0] = 32'h0000_0013; want_f[0] = 1'b1;
    addrs[1] = 32'h0001_4000; want_d[1] = 32'h0000_0013; want_f[1] = 1'b1;
    addrs[2] = 32'h0000_FFFC; want_d[2] = 32'h0000_0013; want_f[2] = 1'b1;
    addrs[3] = 32'h0001_3FFC; want_d[3] = 32'h0000_0000; want_f[3] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      iaddr = addrs[k];
      tick();
      tick();
      tick();
      n_vec++; if (iready_n !== 1'b0) begin n_bad++; $display("FAIL flt%0d_ready: got %b want 0", k, iready_n); end
      n_vec++; if (ifault !== want_f[k]) begin n_bad++; $display("FAIL flt%0d_ifault: got %b want %b", k, ifault, want_f[k]); end
      if (want_f[k]) begin
        n_vec++; if (idata !== want_d[k]) begin n_bad++; $display("FAIL flt%0d_idata: got %h want %h", k, idata, want_d[k]); end
      end
    end
  endtask

  // Overwrite the word being held; access restarts and returns the new word.
  task automatic test_load_restart;
    iaddr = 32'h0001_0004;
    tick();
    tick();
    tick();
    n_vec++; if (idata !== 32'h0010_0113) begin n_bad++; $display("FAIL ld_pre_idata: got %h want 00100113", idata); end
    ld_we   = 1'b1;
    ld_addr = 12'd1;
    ld_data = 32'hDEAD_BEEF;
    tick();
    ld_we = 1'b0;
    n_vec++; if (iready_n !== 1'b1) begin n_bad++; $display("FAIL ld_restart_busy: got %b want 1", iready_n); end
    tick();
    n_vec++; if (iready_n !== 1'b1) begin n_bad++; $display("FAIL ld_busy1: got %b want 1", iready_n); end
    tick();
    n_vec++; if (iready_n !== 1'b0) begin n_bad++; $display("FAIL ld_ready: got %b want 0", iready_n); end
    n_vec++; if (idata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL ld_idata: got %h want deadbeef", idata); end
  endtask

  // Reset while BUSY, then a clean access after release.
  task automatic test_reset_midaccess;
    iaddr = 32'h0001_0000;
    tick();
    rst = 1'b1;
    tick();
    n_vec++; if (iready_n !== 1'b1) begin n_bad++; $display("FAIL mr_iready_n: got %b want 1", iready_n); end
    n_vec++; if (idata !== 32'h0) begin n_bad++; $display("FAIL mr_idata: got %h want 00000000", idata); end
    n_vec++; if (stall_count !== 32'h0) begin n_bad++; $display("FAIL mr_stall: got %0d want 0", stall_count); end
    rst = 1'b0;
    tick();
    n_vec++; if (iready_n !== 1'b1) begin n_bad++; $display("FAIL mr_e0_busy: got %b want 1", iready_n); end
    tick();
    n_vec++; if (iready_n !== 1'b1) begin n_bad++; $display("FAIL mr_e1_busy: got %b want 1", iready_n); end
    tick();
    n_vec++; if (iready_n !== 1'b0) begin n_bad++; $display("FAIL mr_ready: got %b want 0", iready_n); end
    n_vec++; if (idata !== 32'h0000_0093) begin n_bad++; $display("FAIL mr_idata_after: got %h want 00000093", idata); end
  endtask

  initial begin
    n_vec   = 0;
    n_bad   = 0;
    prog[0] = 32'h0000_0093;
    prog[1] = 32'h0010_0113;
    prog[2] = 32'h0020_0193;
    prog[3] = 32'h0030_0213;
    rst     = 1'b1;
    iaddr   = 32'h0001_0000;
    iaddr3  = 32'h0001_0000;
    ld_we   = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    #1;
    test_reset();
    test_sequential();
    test_keep();
    test_abort_lat3();
    test_fault();
    test_load_restart();
    test_reset_midaccess();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
